// File: rtl/lsq_pkg.sv
// Shared types for the parametrised load/store queue: op encodings, size codes, FSM states, entry layout.
// Tags are stored at TAG_W_MAX bits with the unused upper bits held at zero.
package lsq_pkg;

  localparam int TAG_W_MAX = 8;
  typedef logic [TAG_W_MAX-1:0] tag_t;
  localparam tag_t TAG_ZERO = '0;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd2,
    OP_LBU = 4'd3,
    OP_LHU = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7
  } lsq_op_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEM   = 2'd1,
    S_DRAIN = 2'd2
  } lsq_state_t;

  typedef struct packed {
    logic        busy;
    lsq_op_t     op;
    tag_t        rob_tag;
    logic [31:0] base;
    tag_t        base_tag;
    logic [31:0] data;
    tag_t        data_tag;
    logic [31:0] imm;
    logic [31:0] addr;
    logic        addr_rdy;
    logic        st_reported;
    logic        committed;
  } lsq_entry_t;

  function automatic logic is_store(input lsq_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input lsq_op_t op);
    logic [1:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsq_param_if.sv
// Dispatch, CDB, ROB, memory and result signals of the load/store queue.
// slave is the queue side; master is the surrounding core / memory side.
interface lsq_param_if #(
  parameter int TAG_W = 4,
  parameter int N_CDB = 2
);
  import lsq_pkg::*;

  logic                   flush;
  logic                   disp_valid;
  logic                   disp_ready;
  lsq_op_t                disp_op;
  logic [TAG_W-1:0]       disp_rob_tag;
  logic [31:0]            disp_base;
  logic [31:0]            disp_data;
  logic [31:0]            disp_imm;
  logic [TAG_W-1:0]       disp_base_tag;
  logic [TAG_W-1:0]       disp_data_tag;
  logic [N_CDB-1:0]       cdb_valid;
  logic [N_CDB*TAG_W-1:0] cdb_tag;
  logic [N_CDB*32-1:0]    cdb_value;
  logic [TAG_W-1:0]       rob_head_tag;
  logic                   commit_valid;
  logic [TAG_W-1:0]       commit_tag;
  logic                   st_rdy_valid;
  logic [TAG_W-1:0]       st_rdy_tag;
  logic                   mem_req;
  logic                   mem_we;
  logic [1:0]             mem_size;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic                   mem_done;
  logic [31:0]            mem_rdata;
  logic                   res_valid;
  logic [TAG_W-1:0]       res_rob_tag;
  logic [31:0]            res_value;

  modport slave (
    input  flush, disp_valid, disp_op, disp_rob_tag, disp_base, disp_data, disp_imm,
           disp_base_tag, disp_data_tag, cdb_valid, cdb_tag, cdb_value, rob_head_tag,
           commit_valid, commit_tag, mem_done, mem_rdata,
    output disp_ready, st_rdy_valid, st_rdy_tag, mem_req, mem_we, mem_size, mem_addr,
           mem_wdata, res_valid, res_rob_tag, res_value
  );

  modport master (
    output flush, disp_valid, disp_op, disp_rob_tag, disp_base, disp_data, disp_imm,
           disp_base_tag, disp_data_tag, cdb_valid, cdb_tag, cdb_value, rob_head_tag,
           commit_valid, commit_tag, mem_done, mem_rdata,
    input  disp_ready, st_rdy_valid, st_rdy_tag, mem_req, mem_we, mem_size, mem_addr,
           mem_wdata, res_valid, res_rob_tag, res_value
  );

endinterface

// File: rtl/lsq_load_ext.sv
// Sign/zero extension of low-aligned load data by op; purely combinational.
module lsq_load_ext
  import lsq_pkg::*;
(
  input  lsq_op_t     i_op,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_value
);

  always_comb begin
    o_value = i_rdata;
    case (i_op)
      OP_LB:   o_value = {{24{i_rdata[7]}}, i_rdata[7:0]};
      OP_LBU:  o_value = {24'b0, i_rdata[7:0]};
      OP_LH:   o_value = {{16{i_rdata[15]}}, i_rdata[15:0]};
      OP_LHU:  o_value = {16'b0, i_rdata[15:0]};
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsq_param.sv
// Load/store queue: in-order circular buffer, out-of-order address calc, in-order memory access from head.
// Stores touch memory only once committed; committed stores survive a flush.
module lsq_param
  import lsq_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter int          TAG_W   = 4,
  parameter int          N_CDB   = 2,
  parameter logic [31:0] IO_ADDR = 32'h0003_0000
)(
  input  logic        clk,
  input  logic        rst,
  lsq_param_if.slave  lsq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  lsq_entry_t       r_q [DEPTH];
  lsq_entry_t       w_q [DEPTH];
  lsq_entry_t       w_new;
  logic [PW-1:0]    r_head, r_tail, w_head_nxt, w_tail_nxt, w_idx;
  logic [CW-1:0]    r_count, w_count_nxt, w_ccount;
  lsq_state_t       r_state, w_state_nxt;
  logic             w_issue, w_pop, w_skip, w_adv, w_res_set, w_push;
  logic             w_ac_found, w_sr_found;
  logic [TAG_W-1:0] w_sr_tag;

  logic             r_mem_req, r_mem_we;
  logic [1:0]       r_mem_size;
  logic [31:0]      r_mem_addr, r_mem_wdata;
  lsq_op_t          r_mem_op;
  logic [TAG_W-1:0] r_mem_tag;
  logic             r_res_valid, r_st_rdy_valid;
  logic [TAG_W-1:0] r_res_tag, r_st_rdy_tag;
  logic [31:0]      r_res_value, w_ld_val;

  logic [N_CDB-1:0] w_cdb_vld;
  tag_t             w_cdb_tag [N_CDB];
  logic [31:0]      w_cdb_val [N_CDB];

  assign w_cdb_vld = lsq.cdb_valid;
  for (genvar gi = 0; gi < N_CDB; gi++) begin : g_cdb
    assign w_cdb_tag[gi] = tag_t'(lsq.cdb_tag[gi*TAG_W +: TAG_W]);
    assign w_cdb_val[gi] = lsq.cdb_value[gi*32 +: 32];
  end

  // Scans from the highest bus down so the lowest matching bus index wins.
  function automatic logic [32:0] cdb_lookup(input tag_t t);
    logic [32:0] r;
    r = '0;
    for (int b = N_CDB - 1; b >= 0; b--) begin
      if (w_cdb_vld[b] && (t != TAG_ZERO) && (w_cdb_tag[b] == t)) r = {1'b1, w_cdb_val[b]};
    end
    return r;
  endfunction

  function automatic lsq_entry_t snoop_entry(input lsq_entry_t e);
    lsq_entry_t  r;
    logic [32:0] lb, ld;
    r  = e;
    lb = cdb_lookup(e.base_tag);
    ld = cdb_lookup(e.data_tag);
    if (lb[32]) begin
      r.base     = lb[31:0];
      r.base_tag = TAG_ZERO;
    end
    if (ld[32]) begin
      r.data     = ld[31:0];
      r.data_tag = TAG_ZERO;
    end
    return r;
  endfunction

  assign lsq.disp_ready = (r_count != CW'(DEPTH));
  assign w_push = lsq.disp_valid && lsq.disp_ready && !lsq.flush;
  assign w_adv  = w_pop || w_skip;

  always_comb begin
    w_new          = '0;
    w_new.busy     = 1'b1;
    w_new.op       = lsq.disp_op;
    w_new.rob_tag  = tag_t'(lsq.disp_rob_tag);
    w_new.base     = lsq.disp_base;
    w_new.base_tag = tag_t'(lsq.disp_base_tag);
    w_new.data     = lsq.disp_data;
    w_new.data_tag = is_store(lsq.disp_op) ? tag_t'(lsq.disp_data_tag) : TAG_ZERO;
    w_new.imm      = lsq.disp_imm;
    w_new          = snoop_entry(w_new);
  end

  // Head FSM: only the head entry ever touches memory.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_pop       = 1'b0;
    w_skip      = 1'b0;
    w_res_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!lsq.flush && r_q[r_head].busy && r_q[r_head].addr_rdy) begin
          if (is_store(r_q[r_head].op))
            w_issue = r_q[r_head].committed && (r_q[r_head].data_tag == TAG_ZERO);
          else
            w_issue = (r_q[r_head].addr != IO_ADDR) ||
                      (tag_t'(lsq.rob_head_tag) == r_q[r_head].rob_tag);
          if (w_issue) w_state_nxt = S_MEM;
        end
      end
      S_MEM: begin
        if (r_mem_we) begin
          if (lsq.mem_done) begin
            w_pop       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (lsq.flush) begin
          w_skip      = 1'b1;
          w_state_nxt = lsq.mem_done ? S_IDLE : S_DRAIN;
        end else if (lsq.mem_done) begin
          w_pop       = 1'b1;
          w_res_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (lsq.mem_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_q        = r_q;
    w_idx      = '0;
    w_ac_found = 1'b0;
    w_sr_found = 1'b0;
    w_sr_tag   = '0;
    w_ccount   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q[i].busy) w_q[i] = snoop_entry(r_q[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (!w_ac_found && r_q[w_idx].busy && (r_q[w_idx].base_tag == TAG_ZERO) &&
          !r_q[w_idx].addr_rdy) begin
        w_ac_found          = 1'b1;
        w_q[w_idx].addr     = r_q[w_idx].base + r_q[w_idx].imm;
        w_q[w_idx].addr_rdy = 1'b1;
      end
      if (!w_sr_found && !lsq.flush && r_q[w_idx].busy && is_store(r_q[w_idx].op) &&
          r_q[w_idx].addr_rdy && (r_q[w_idx].data_tag == TAG_ZERO) &&
          !r_q[w_idx].st_reported) begin
        w_sr_found             = 1'b1;
        w_q[w_idx].st_reported = 1'b1;
        w_sr_tag               = r_q[w_idx].rob_tag[TAG_W-1:0];
      end
    end
    if (lsq.commit_valid && !lsq.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q[i].busy && is_store(r_q[i].op) && (r_q[i].rob_tag != TAG_ZERO) &&
            (r_q[i].rob_tag == tag_t'(lsq.commit_tag)))
          w_q[i].committed = 1'b1;
      end
    end
    if (w_adv) w_q[r_head] = '0;
    if (lsq.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!r_q[i].committed) w_q[i] = '0;
        if (r_q[i].busy && r_q[i].committed) w_ccount = w_ccount + CW'(1);
      end
    end
    if (w_push) w_q[r_tail] = w_new;
  end

  // An in-flight load being flushed is stepped over so committed stores behind it keep their slots.
  always_comb begin
    w_head_nxt = r_head + PW'(w_adv);
    if (lsq.flush) begin
      w_tail_nxt  = r_head + PW'(w_skip) + PW'(w_ccount);
      w_count_nxt = w_ccount - CW'(w_pop);
    end else begin
      w_tail_nxt  = r_tail + PW'(w_push);
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  lsq_load_ext u_ext (
    .i_op    (r_mem_op),
    .i_rdata (lsq.mem_rdata),
    .o_value (w_ld_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_size     <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_op       <= OP_LB;
      r_mem_tag      <= '0;
      r_res_valid    <= 1'b0;
      r_res_tag      <= '0;
      r_res_value    <= '0;
      r_st_rdy_valid <= 1'b0;
      r_st_rdy_tag   <= '0;
    end else begin
      r_q            <= w_q;
      r_head         <= w_head_nxt;
      r_tail         <= w_tail_nxt;
      r_count        <= w_count_nxt;
      r_st_rdy_valid <= w_sr_found;
      r_st_rdy_tag   <= w_sr_tag;
      r_res_valid    <= w_res_set;
      if (w_res_set) begin
        r_res_tag   <= r_mem_tag;
        r_res_value <= w_ld_val;
      end
      if (w_issue) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= is_store(r_q[r_head].op);
        r_mem_size  <= op_size(r_q[r_head].op);
        r_mem_addr  <= r_q[r_head].addr;
        r_mem_wdata <= is_store(r_q[r_head].op) ? r_q[r_head].data : 32'h0;
        r_mem_op    <= r_q[r_head].op;
        r_mem_tag   <= r_q[r_head].rob_tag[TAG_W-1:0];
      end else if ((r_state != S_IDLE) && lsq.mem_done) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  assign lsq.mem_req      = r_mem_req;
  assign lsq.mem_we       = r_mem_we;
  assign lsq.mem_size     = r_mem_size;
  assign lsq.mem_addr     = r_mem_addr;
  assign lsq.mem_wdata    = r_mem_wdata;
  assign lsq.res_valid    = r_res_valid && !lsq.flush;
  assign lsq.res_rob_tag  = r_res_tag;
  assign lsq.res_value    = r_res_value;
  assign lsq.st_rdy_valid = r_st_rdy_valid && !lsq.flush;
  assign lsq.st_rdy_tag   = r_st_rdy_tag;

endmodule

// File: doc/lsq_param.md
Name: lsq_param

Overview:
- Parametrised load/store queue for the out-of-order RV32I core. Successor to the fixed 15-entry load/store buffer.
- Sits between decode/dispatch, the CDB ports, the ROB and the memory controller.
- Holds memory ops in program order and computes effective addresses out of order. Executes memory accesses in order from the head.
- Adds over the previous block:
  - configurable depth and CDB count;
  - stores write memory only after ROB commit;
  - committed stores survive a misbranch flush;
  - load sign/zero extension is done locally.

Parameters:
DEPTH, 16, queue entries; power of two, >=2
TAG_W, 4, ROB tag width; tag 0 = "no dependency/invalid"
N_CDB, 2, number of snooped result buses
IO_ADDR, 32'h0003_0000, memory-mapped I/O address; loads there are non-speculative

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  misbranch flush
disp_valid  in  1  dispatch entry this cycle
disp_ready  out  1  queue not full
disp_op  in  4  lsq_op_t (LB,LH,LW,LBU,LHU,SB,SH,SW)
disp_rob_tag  in  TAG_W  ROB tag of instruction
disp_base, disp_data, disp_imm  in  32 each  rs1 value, rs2 value (stores), sign-extended offset
disp_base_tag, disp_data_tag  in  TAG_W each  pending producer tags (0 = value valid)
cdb_valid  in  N_CDB  per-bus valid
cdb_tag  in  N_CDB*TAG_W  flattened tags, bus i at [i*TAG_W +: TAG_W]
cdb_value  in  N_CDB*32  flattened values
rob_head_tag  in  TAG_W  tag at ROB head
commit_valid, commit_tag  in  1, TAG_W  ROB commits a store
st_rdy_valid, st_rdy_tag  out  1, TAG_W  store address+data resolved, to ROB
mem_req, mem_we  out  1 each  request / write
mem_size  out  2  0 byte, 1 half, 2 word
mem_addr, mem_wdata  out  32 each
mem_done  in  1  one-cycle completion pulse
mem_rdata  in  32  raw read data, low-aligned
res_valid, res_rob_tag, res_value  out  1, TAG_W, 32  load result broadcast

Behaviour:
- Circular buffer:
  - head/tail pointers of $clog2(DEPTH) bits, wrapping naturally.
  - count of $clog2(DEPTH)+1 bits.
  - disp_ready = (count != DEPTH); there is no same-cycle pop bypass.
- Dispatch (disp_valid && disp_ready):
  - writes entry at tail.
  - Same-cycle forwarding: any disp_*_tag matching a valid CDB bus captures that value with tag 0.
- Snooping: every busy entry with a nonzero operand tag equal to a valid cdb_tag captures that value; the lowest bus index wins.
- Address calc: one per cycle. Picks the oldest (from head) entry with base_tag==0 and !addr_rdy; addr = base + imm, mod 2^32.
- Store readiness: when addr_rdy && data_tag==0 && !st_reported, pulse st_rdy_valid/st_rdy_tag for one cycle and set st_reported.
- Commit: commit_valid with commit_tag equal to a busy store entry sets its committed bit.
- Head FSM, states IDLE / MEM / DRAIN:
  - IDLE, load at head with addr_rdy:
    - Not IO: issue immediately.
    - IO: issue only when rob_head_tag == its tag.
    - Issue drives mem_req=1, mem_we=0, size, addr; go to MEM.
  - IDLE, committed store at head: mem_req=1, mem_we=1, wdata = data; go to MEM.
  - MEM: mem_req and all fields held stable until mem_done.
    - On mem_done: deassert mem_req next cycle and pop head.
    - If the op was a load, register res_valid=1, res_rob_tag, res_value the cycle after mem_done (LB/LH sign-extend, LBU/LHU zero-extend).
    - Return to IDLE.
  - DRAIN: entered when flush arrives while a load is in MEM.
    - mem_req stays held until mem_done.
    - The returned data is discarded (no res_valid).
    - Then IDLE.
- Flush:
  - All uncommitted entries are freed. Committed stores are contiguous from head and remain.
  - tail = head + committed_count.
  - A store in MEM continues normally; a load in MEM goes to DRAIN.
  - res_valid and st_rdy_valid are forced 0 that cycle.
  - A dispatch in the flush cycle is ignored.
  - Flush has priority over commit of the same tag.
- Reset:
  - All outputs 0; disp_ready=1; FSM IDLE; head=tail=count=0; all busy/committed/reported bits cleared.
  - Mid-transaction reset abandons the access; the memory controller is reset with it.
- The LSQ does not snoop its own result; top level routes res_* into a CDB port.

Decomposition:
- Package lsq_pkg:
  - lsq_op_t enum;
  - mem size encodings;
  - TAG_ZERO constant;
  - entry struct {busy, op, rob_tag, base, base_tag, data, data_tag, imm, addr, addr_rdy, st_reported, committed}.
- Sub-module lsq_load_ext: combinational byte/half sign/zero extension of mem_rdata by op.

Test Plan:
1. LW base_tag=3 (pending), imm=8; cdb tag 3 value 0x100 -> mem_req addr 0x108 size 2; mem_done rdata 0xDEADBEEF -> next cycle res_value 0xDEADBEEF, res_rob_tag correct.
2. LB and LBU at the same address, rdata 0x80 -> res_value 0xFFFFFF80 then 0x00000080.
3. SW tag 5, addr/data ready -> single st_rdy pulse with tag 5; no mem_req until commit_valid tag 5, then write with mem_we=1 and correct wdata.
4. Fill DEPTH entries -> disp_ready=0; pop one -> disp_ready=1 the next cycle. Wrap tail past DEPTH-1 and verify order is preserved.
5. Two committed stores + three pending loads, one load in MEM, then flush -> stores still written; the in-flight load's mem_done produces no res_valid; count=2 after flush.
6. LW to IO_ADDR -> no mem_req until rob_head_tag matches; dispatch with disp_base_tag equal to a same-cycle CDB tag captures the value.
